// File: rtl/riscv_soc.sv
// Minimal RV32I SoC: two-stage core (IF, EX/WB), instruction ROM and word data RAM.
// Everything runs on clk_100MHz; arst_n is a synchronous active-low reset.

module riscv_rom #(
    parameter int DEPTH = 4096
) (
    input  logic [31:0] addr,
    output logic [31:0] data
);
    localparam int AW = $clog2(DEPTH);

    // Contents are preloaded by the simulation environment; hardware never writes it.
    logic [31:0] _rom [0:DEPTH-1];

    logic unused_addr;
    assign unused_addr = &{1'b0, addr[31:AW+2], addr[1:0]};

    assign data = _rom[addr[AW+1:2]];
endmodule

module riscv_soc #(
    parameter int          ROM_DEPTH = 4096,
    parameter int          RAM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk_100MHz,
    input logic arst_n,
    input logic hold
);
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          RAM_AW = $clog2(RAM_DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] rom_data;
    logic [31:0] regs [0:31];
    logic [31:0] ram  [0:RAM_DEPTH-1];

    riscv_rom #(.DEPTH(ROM_DEPTH)) u_rom (
        .addr (pc),
        .data (rom_data)
    );

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, op_b, alu_res, mem_addr;
    logic [31:0] rd_val, target;
    logic        rd_we, ram_we, taken, alu_legal;
    logic [RAM_AW-1:0] ram_idx;

    assign opcode = ifid_instr[6:0];
    assign rd     = ifid_instr[11:7];
    assign funct3 = ifid_instr[14:12];
    assign rs1    = ifid_instr[19:15];
    assign rs2    = ifid_instr[24:20];
    assign funct7 = ifid_instr[31:25];

    assign imm_i = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    assign imm_s = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
    assign imm_b = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                    ifid_instr[30:25], ifid_instr[11:8], 1'b0};
    assign imm_u = {ifid_instr[31:12], 12'b0};
    assign imm_j = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                    ifid_instr[20], ifid_instr[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign op_b     = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign shamt    = op_b[4:0];
    assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign ram_idx  = mem_addr[RAM_AW+1:2];

    logic unused_mem;
    assign unused_mem = &{1'b0, mem_addr[31:RAM_AW+2], mem_addr[1:0]};

    // Shared ALU for OP and OP-IMM; funct7 only selects SUB on register ops.
    always_comb begin
        alu_res = 32'd0;
        case (funct3)
            3'b000: alu_res = (opcode == OPC_OP && funct7[5]) ? rs1_val - op_b : rs1_val + op_b;
            3'b001: alu_res = rs1_val << shamt;
            3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
            3'b011: alu_res = {31'd0, rs1_val < op_b};
            3'b100: alu_res = rs1_val ^ op_b;
            3'b101: alu_res = funct7[5] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110: alu_res = rs1_val | op_b;
            default: alu_res = rs1_val & op_b;
        endcase
    end

    // Reject funct7 patterns that are not part of RV32I integer ops.
    always_comb begin
        alu_legal = 1'b0;
        if (opcode == OPC_IMM) begin
            if (funct3 == 3'b001)      alu_legal = (funct7 == 7'b0000000);
            else if (funct3 == 3'b101) alu_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            else                       alu_legal = 1'b1;
        end else if (opcode == OPC_OP) begin
            alu_legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        end
    end

    // EX/WB decode: writeback value, store enable and control transfer.
    always_comb begin
        rd_we  = 1'b0;
        rd_val = 32'd0;
        ram_we = 1'b0;
        taken  = 1'b0;
        target = ifid_pc + imm_b;
        case (opcode)
            OPC_LUI: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            OPC_AUIPC: begin
                rd_we  = 1'b1;
                rd_val = ifid_pc + imm_u;
            end
            OPC_JAL: begin
                rd_we  = 1'b1;
                rd_val = ifid_pc + 32'd4;
                taken  = 1'b1;
                target = ifid_pc + imm_j;
            end
            OPC_JALR: if (funct3 == 3'b000) begin
                rd_we  = 1'b1;
                rd_val = ifid_pc + 32'd4;
                taken  = 1'b1;
                target = (rs1_val + imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000: taken = (rs1_val == rs2_val);
                    3'b001: taken = (rs1_val != rs2_val);
                    3'b100: taken = ($signed(rs1_val) <  $signed(rs2_val));
                    3'b101: taken = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110: taken = (rs1_val <  rs2_val);
                    3'b111: taken = (rs1_val >= rs2_val);
                    default: taken = 1'b0;
                endcase
            end
            OPC_LOAD: if (funct3 == 3'b010) begin
                rd_we  = 1'b1;
                rd_val = ram[ram_idx];
            end
            OPC_STORE: ram_we = (funct3 == 3'b010);
            OPC_IMM, OPC_OP: begin
                rd_we  = alu_legal;
                rd_val = alu_res;
            end
            default: ;
        endcase
    end

    // Fetch, pipeline register and register file; hold freezes all of it.
    always_ff @(posedge clk_100MHz) begin
        if (!arst_n) begin
            pc         <= RESET_PC;
            ifid_instr <= NOP;
            ifid_pc    <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (!hold) begin
            if (taken) begin
                pc         <= target;
                ifid_instr <= NOP;
                ifid_pc    <= pc;
            end else begin
                pc         <= pc + 32'd4;
                ifid_instr <= rom_data;
                ifid_pc    <= pc;
            end
            if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
        end
    end

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clk_100MHz) begin
        if (arst_n && !hold && ram_we) ram[ram_idx] <= rs2_val;
    end
endmodule

// File: tb/tb_riscv_soc.sv
// Directed bench for riscv_soc: loads small programs into the ROM, runs them and
// compares pc / register / RAM state against expectations queued beforehand.

module tb_riscv_soc;
    logic clk_100MHz = 1'b0;
    logic arst_n = 1'b0;
    logic hold = 1'b0;

    riscv_soc dut (
        .clk_100MHz (clk_100MHz),
        .arst_n     (arst_n),
        .hold       (hold)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        string       tag;
        int          kind;   // 0 = pc, 1 = register, 2 = RAM word
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          n_assert = 0;
    int          n_fail = 0;

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] shi(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] sh);
        return {f7, sh, rs1, f3, rd, 7'h13};
    endfunction
    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 4096; i++) dut.u_rom._rom[i] = 32'h0000_0013;
        for (int i = 0; i < prog.size(); i++) dut.u_rom._rom[i] = prog[i];
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic expect_val(input string tag, input int kind, input int idx, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = dut.pc;
                1:       obs = dut.regs[e.idx];
                default: obs = dut.ram[e.idx];
            endcase
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        hold   = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // Reset state and first fetch timing, using the arithmetic program.
        prog = '{addi(1, 0, 12'd5), addi(2, 1, 12'd3), rtype(7'h20, 3'b000, 3, 2, 1), shi(7'h00, 3'b001, 4, 1, 5'd4)};
        load_prog();
        do_reset();
        expect_val("reset_pc", 0, 0, 32'h0);
        for (int i = 0; i < 32; i++) expect_val($sformatf("reset_x%0d", i), 1, i, 32'h0);
        check();
        arst_n = 1'b1;
        tick();
        expect_val("pc_edge1", 0, 0, 32'h4);
        check();
        tick();
        expect_val("pc_edge2", 0, 0, 32'h8);
        expect_val("x1_first_wb", 1, 1, 32'd5);
        check();
        for (int i = 0; i < 6; i++) tick();
        expect_val("arith_x1", 1, 1, 32'd5);
        expect_val("arith_x2", 1, 2, 32'd8);
        expect_val("arith_x3", 1, 3, 32'd3);
        expect_val("arith_x4", 1, 4, 32'd80);
        check();

        // Reset again clears a populated register file.
        do_reset();
        expect_val("rereset_x2", 1, 2, 32'h0);
        expect_val("rereset_x4", 1, 4, 32'h0);
        expect_val("rereset_pc", 0, 0, 32'h0);
        check();

        // Memory: store then load of all-ones.
        prog = '{addi(1, 0, 12'hFFF), sw(1, 0, 12'd8), lw(5, 0, 12'd8)};
        load_prog();
        do_reset();
        arst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        expect_val("mem_x5", 1, 5, 32'hFFFF_FFFF);
        expect_val("mem_ram2", 2, 2, 32'hFFFF_FFFF);
        check();

        // Control flow: taken beq, jal, not-taken bne, with edge-accurate timing.
        prog = '{addi(2, 0, 12'd1), br(3'b000, 0, 0, 13'd8), addi(2, 0, 12'd9), addi(3, 0, 12'd4),
                 jal(1, 21'd12), addi(4, 0, 12'd1), addi(4, 0, 12'd2), addi(5, 0, 12'd7),
                 br(3'b001, 0, 0, 13'd8), addi(6, 0, 12'd3), addi(6, 6, 12'd1)};
        load_prog();
        do_reset();
        arst_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            if (e == 3)  expect_val("beq_target_pc", 0, 0, 32'h0000_000C);
            if (e == 6)  expect_val("jal_target_pc", 0, 0, 32'h0000_001C);
            if (e == 7)  expect_val("jal_bubble_x5", 1, 5, 32'd0);
            if (e == 8)  expect_val("jal_dest_x5", 1, 5, 32'd7);
            if (e == 9)  expect_val("bne_nt_pc", 0, 0, 32'h0000_0028);
            if (e == 10) expect_val("bne_nt_x6_a", 1, 6, 32'd3);
            if (e == 11) expect_val("bne_nt_x6_b", 1, 6, 32'd4);
            tick();
            check();
        end
        expect_val("beq_skip_x2", 1, 2, 32'd1);
        expect_val("beq_after_x3", 1, 3, 32'd4);
        expect_val("jal_link_x1", 1, 1, 32'h0000_0014);
        expect_val("jal_skip_x4", 1, 4, 32'd0);
        check();

        // Signedness, shifts, x0 hardwiring and an ECALL treated as NOP.
        prog = '{addi(1, 0, 12'hFFF), addi(2, 0, 12'd1), rtype(7'h00, 3'b010, 3, 1, 2),
                 rtype(7'h00, 3'b011, 4, 1, 2), shi(7'h20, 3'b101, 5, 1, 5'd4),
                 shi(7'h00, 3'b101, 6, 1, 5'd4), addi(0, 0, 12'd7), 32'h0000_0073};
        load_prog();
        do_reset();
        arst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        expect_val("slt_x3", 1, 3, 32'd1);
        expect_val("sltu_x4", 1, 4, 32'd0);
        expect_val("srai_x5", 1, 5, 32'hFFFF_FFFF);
        expect_val("srli_x6", 1, 6, 32'h0FFF_FFFF);
        expect_val("x0_zero", 1, 0, 32'd0);
        expect_val("ecall_x7", 1, 7, 32'd0);
        check();

        // Hold for five edges mid-program, then finish as a hold-free run would.
        prog = '{addi(1, 0, 12'd5), addi(2, 1, 12'd3), rtype(7'h20, 3'b000, 3, 2, 1), shi(7'h00, 3'b001, 4, 1, 5'd4)};
        load_prog();
        do_reset();
        arst_n = 1'b1;
        tick();
        tick();
        tick();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_val("hold_pc", 0, 0, 32'h0000_000C);
            expect_val("hold_x2", 1, 2, 32'd8);
            expect_val("hold_x3", 1, 3, 32'd0);
            check();
        end
        hold = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        expect_val("hold_final_x1", 1, 1, 32'd5);
        expect_val("hold_final_x2", 1, 2, 32'd8);
        expect_val("hold_final_x3", 1, 3, 32'd3);
        expect_val("hold_final_x4", 1, 4, 32'd80);
        check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
